// File: rtl/hack_pkg.sv
// Shared types and instruction-field positions for the Hack core.
package hack_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // C_BIT sits at the top of the word, so it moves with DATA_W.
    function automatic int unsigned c_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

    localparam int unsigned A_BIT    = 12;
    localparam int unsigned COMP_LSB = 6;
    localparam int unsigned DEST_A   = 5;
    localparam int unsigned DEST_D   = 4;
    localparam int unsigned DEST_M   = 3;
    localparam int unsigned JMP_LT   = 2;
    localparam int unsigned JMP_EQ   = 1;
    localparam int unsigned JMP_GT   = 0;

    localparam logic [5:0] COMP_ZERO = 6'b101010;
    localparam logic [5:0] COMP_D    = 6'b001100;
    localparam logic [5:0] COMP_A    = 6'b110000;
    localparam logic [5:0] COMP_DP1  = 6'b011111;

endpackage

// File: rtl/hack_if.sv
// Instruction-fetch and data-memory bus between the core and ROM/RAM/MMIO.
interface hack_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 15
);
    logic              inst_req;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;
    logic              data_rd;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              retire;

    modport master (
        output inst_req, inst_addr, data_rd, data_addr, wdata, we, retire,
        input  inst_valid, inst, rdata_valid, rdata
    );

    modport slave (
        input  inst_req, inst_addr, data_rd, data_addr, wdata, we, retire,
        output inst_valid, inst, rdata_valid, rdata
    );
endinterface

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zx/nx/zy/ny pre-conditioning, add-or-and, optional negate.
module hack_alu #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [5:0]        fn,
    output logic [DATA_W-1:0] out,
    output logic              zero
);
    logic [DATA_W-1:0] xz, xn, yz, yn, f;

    always_comb begin
        xz   = fn[5] ? '0 : x;
        xn   = fn[4] ? ~xz : xz;
        yz   = fn[3] ? '0 : y;
        yn   = fn[2] ? ~yz : yz;
        f    = fn[1] ? (xn + yn) : (xn & yn);
        out  = fn[0] ? ~f : f;
        zero = (out == '0);
    end
endmodule

// File: rtl/hack_core.sv
// Multi-cycle Hack CPU core: FETCH -> (READ) -> EXEC, with handshaked fetch and stalling M reads.
module hack_core
    import hack_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CPUclk,
    input  logic              nrst,
    hack_if.master            bus,
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] d_q
);
    localparam int unsigned C_BIT = c_bit(DATA_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_d, d_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] alu_y, alu_out;
    logic              alu_zr, alu_ng, is_c, jump;

    assign is_c   = ir_q[C_BIT];
    assign alu_y  = ir_q[A_BIT] ? m_q : a_q;
    assign alu_ng = alu_out[DATA_W-1];
    assign jump   = is_c & ((ir_q[JMP_LT] & alu_ng) |
                            (ir_q[JMP_EQ] & alu_zr) |
                            (ir_q[JMP_GT] & ~alu_ng & ~alu_zr));

    hack_alu #(.DATA_W(DATA_W)) u_alu (
        .x    (d_q),
        .y    (alu_y),
        .fn   (ir_q[COMP_LSB +: 6]),
        .out  (alu_out),
        .zero (alu_zr)
    );

    // Address and write data always reflect the pre-instruction A and the live ALU result.
    assign bus.inst_addr = pc_q;
    assign bus.data_addr = a_q[ADDR_W-1:0];
    assign bus.wdata     = alu_out;

    always_ff @(posedge CPUclk) begin
        if (!nrst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            m_q     <= m_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        a_d          = a_q;
        d_d          = d_q;
        ir_d         = ir_q;
        m_d          = m_q;
        bus.inst_req = 1'b0;
        bus.data_rd  = 1'b0;
        bus.we       = 1'b0;
        bus.retire   = 1'b0;

        case (state_q)
            FETCH: begin
                bus.inst_req = 1'b1;
                if (bus.inst_valid) begin
                    ir_d    = bus.inst;
                    state_d = (bus.inst[C_BIT] && bus.inst[A_BIT]) ? READ : EXEC;
                end
            end
            READ: begin
                bus.data_rd = 1'b1;
                if (bus.rdata_valid) begin
                    m_d     = bus.rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                bus.retire = 1'b1;
                state_d    = FETCH;
                pc_d       = jump ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                if (!is_c) begin
                    a_d = {1'b0, ir_q[DATA_W-2:0]};
                end else begin
                    if (ir_q[DEST_A]) a_d = alu_out;
                    if (ir_q[DEST_D]) d_d = alu_out;
                    bus.we = ir_q[DEST_M];
                end
            end
            default: state_d = FETCH;
        endcase

        if (!nrst) begin
            bus.inst_req = 1'b0;
            bus.data_rd  = 1'b0;
            bus.we       = 1'b0;
            bus.retire   = 1'b0;
        end
    end
endmodule

// File: tb/tb_hack_core.sv
// Scoreboarded bench for hack_core: a 16-bit core running a short program, plus a 24-bit instance.
module tb_hack_core;

    logic        CPUclk = 1'b0;
    logic        nrst   = 1'b0;
    logic [15:0] a_q, d_q;
    logic [23:0] a24, d24;

    hack_if #(.DATA_W(16), .ADDR_W(15)) bus ();
    hack_if #(.DATA_W(24), .ADDR_W(20)) bus24 ();

    hack_core #(.DATA_W(16), .ADDR_W(15), .RESET_PC(15'd0)) u_dut (
        .CPUclk (CPUclk),
        .nrst   (nrst),
        .bus    (bus.master),
        .a_q    (a_q),
        .d_q    (d_q)
    );

    hack_core #(.DATA_W(24), .ADDR_W(20), .RESET_PC(20'd0)) u_dut24 (
        .CPUclk (CPUclk),
        .nrst   (nrst),
        .bus    (bus24.master),
        .a_q    (a24),
        .d_q    (d24)
    );

    always #5 CPUclk = ~CPUclk;

    typedef struct {
        string       tag;
        logic        we;
        logic [15:0] wdata;
        logic [14:0] daddr;
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
        int unsigned gap;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_tests  = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned last_ret = 0;

    always @(posedge CPUclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic we, input logic [15:0] wdata,
                                input logic [14:0] daddr, input logic [14:0] pc,
                                input logic [15:0] a, input logic [15:0] d, input int unsigned gap);
        exp_t e;
        e.tag = tag; e.we = we; e.wdata = wdata; e.daddr = daddr;
        e.pc = pc; e.a = a; e.d = d; e.gap = gap;
        return e;
    endfunction

    // Presents one instruction when the core asks for it, then serves any M read.
    task automatic do_inst(input logic [15:0] instr, input int unsigned rdelay,
                           input logic [15:0] rd, input exp_t e);
        int unsigned n, cnt;
        n = 0;
        while (!bus.inst_req && n < 20) begin
            @(negedge CPUclk);
            n++;
        end
        if (!bus.inst_req) begin
            check({e.tag, ".fetch_timeout"}, 32'(0), 32'(1));
            return;
        end
        sb.push_back(e);
        bus.inst       = instr;
        bus.inst_valid = 1'b1;
        @(negedge CPUclk);
        bus.inst_valid = 1'b0;
        if (instr[15] && instr[12]) begin
            cnt = 0;
            check({e.tag, ".rd_addr"}, 32'(bus.data_addr), 32'(e.daddr));
            bus.rdata = 16'hDEAD;
            for (int unsigned i = 0; i < rdelay; i++) begin
                if (bus.data_rd) cnt++;
                @(negedge CPUclk);
            end
            if (bus.data_rd) cnt++;
            bus.rdata       = rd;
            bus.rdata_valid = 1'b1;
            @(negedge CPUclk);
            bus.rdata_valid = 1'b0;
            check({e.tag, ".rd_cycles"}, 32'(cnt), 32'(rdelay + 1));
        end
    endtask

    // Retire monitor: pops the scoreboard and checks EXEC outputs, then the committed state.
    initial begin
        exp_t e;
        forever begin
            @(negedge CPUclk);
            if (nrst && bus.retire) begin
                if (sb.size() == 0) begin
                    check("spurious_retire", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check({e.tag, ".we"}, 32'(bus.we), 32'(e.we));
                    if (e.we) check({e.tag, ".wdata"}, 32'(bus.wdata), 32'(e.wdata));
                    check({e.tag, ".daddr"}, 32'(bus.data_addr), 32'(e.daddr));
                    if (e.gap != 0) check({e.tag, ".gap"}, cyc - last_ret, e.gap);
                    last_ret = cyc;
                    @(posedge CPUclk);
                    #1;
                    check({e.tag, ".pc"}, 32'(bus.inst_addr), 32'(e.pc));
                    check({e.tag, ".a"}, 32'(a_q), 32'(e.a));
                    check({e.tag, ".d"}, 32'(d_q), 32'(e.d));
                    check({e.tag, ".we_after"}, 32'(bus.we), 32'(0));
                    check({e.tag, ".retire_after"}, 32'(bus.retire), 32'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        bus.inst_valid    = 1'b1;
        bus.inst          = '0;
        bus.rdata_valid   = 1'b0;
        bus.rdata         = '0;
        bus24.inst_valid  = 1'b1;
        bus24.inst        = '0;
        bus24.rdata_valid = 1'b0;
        bus24.rdata       = '0;

        nrst = 1'b0;
        repeat (3) @(posedge CPUclk);
        @(negedge CPUclk);
        check("rst.inst_addr", 32'(bus.inst_addr), 32'(0));
        check("rst.data_addr", 32'(bus.data_addr), 32'(0));
        check("rst.wdata", 32'(bus.wdata), 32'(0));
        check("rst.we", 32'(bus.we), 32'(0));
        check("rst.retire", 32'(bus.retire), 32'(0));
        check("rst.inst_req", 32'(bus.inst_req), 32'(0));
        check("rst.a", 32'(a_q), 32'(0));
        check("rst.d", 32'(d_q), 32'(0));
        nrst             = 1'b1;
        bus.inst_valid   = 1'b0;
        bus24.inst_valid = 1'b0;
        #1;
        check("rst.inst_req_rise", 32'(bus.inst_req), 32'(1));

        do_inst(16'h0005, 0, 0, mk("i01_at5",     0, 0, 15'h0,    15'd1,    16'd5,    16'd0,    0));
        do_inst(16'hEC10, 0, 0, mk("i02_DeqA",    0, 0, 15'h5,    15'd2,    16'd5,    16'd5,    2));
        do_inst(16'h0064, 0, 0, mk("i03_at100",   0, 0, 15'h5,    15'd3,    16'd100,  16'd5,    2));
        do_inst(16'hE7C8, 0, 0, mk("i04_MeqDp1",  1, 6, 15'd100,  15'd4,    16'd100,  16'd5,    2));
        do_inst(16'h0007, 0, 0, mk("i05_at7",     0, 0, 15'd100,  15'd5,    16'd7,    16'd5,    2));
        do_inst(16'hFC10, 3, 16'h1234,
                                mk("i06_DeqM",    0, 0, 15'd7,    15'd6,    16'd7,    16'h1234, 6));
        do_inst(16'h0003, 0, 0, mk("i07_at3",     0, 0, 15'd7,    15'd7,    16'd3,    16'h1234, 2));
        do_inst(16'hEC10, 0, 0, mk("i08_DeqA",    0, 0, 15'd3,    15'd8,    16'd3,    16'd3,    2));
        do_inst(16'h0014, 0, 0, mk("i09_at20",    0, 0, 15'd3,    15'd9,    16'd20,   16'd3,    2));
        do_inst(16'hE301, 0, 0, mk("i10_JGT_tk",  0, 0, 15'd20,   15'd20,   16'd20,   16'd3,    2));
        do_inst(16'hEA90, 0, 0, mk("i11_Deq0",    0, 0, 15'd20,   15'd21,   16'd20,   16'd0,    2));
        do_inst(16'hE301, 0, 0, mk("i12_JGT_nt",  0, 0, 15'd20,   15'd22,   16'd20,   16'd0,    2));
        do_inst(16'hEA87, 0, 0, mk("i13_JMP",     0, 0, 15'd20,   15'd20,   16'd20,   16'd0,    2));
        do_inst(16'hEDE7, 0, 0, mk("i14_AJMP",    0, 0, 15'd20,   15'd20,   16'd21,   16'd0,    2));
        do_inst(16'h7FFF, 0, 0, mk("i15_at7FFF",  0, 0, 15'd21,   15'd21,   16'h7FFF, 16'd0,    2));
        do_inst(16'hEA87, 0, 0, mk("i16_JMPtop",  0, 0, 15'h7FFF, 15'h7FFF, 16'h7FFF, 16'd0,    2));
        do_inst(16'h0000, 0, 0, mk("i17_wrap",    0, 0, 15'h7FFF, 15'd0,    16'd0,    16'd0,    2));
        do_inst(16'hEE90, 0, 0, mk("i18_Dm1",     0, 0, 15'd0,    15'd1,    16'd0,    16'hFFFF, 2));
        do_inst(16'h0005, 0, 0, mk("i19_at5",     0, 0, 15'd0,    15'd2,    16'd5,    16'hFFFF, 2));
        do_inst(16'hE304, 0, 0, mk("i20_JLT_tk",  0, 0, 15'd5,    15'd5,    16'd5,    16'hFFFF, 2));
        do_inst(16'hE7E8, 0, 0, mk("i21_AMeqDp1", 1, 0, 15'd5,    15'd6,    16'd0,    16'hFFFF, 2));

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge CPUclk);
            n++;
        end
        check("sb_drain", 32'(sb.size()), 32'(0));
        repeat (2) @(negedge CPUclk);

        // Reset while a data read is stalled; the late rdata_valid must not land.
        n = 0;
        while (!bus.inst_req && n < 20) begin
            @(negedge CPUclk);
            n++;
        end
        check("rr.fetch_ready", 32'(bus.inst_req), 32'(1));
        bus.inst       = 16'hFC10;
        bus.inst_valid = 1'b1;
        @(negedge CPUclk);
        bus.inst_valid = 1'b0;
        check("rr.in_read", 32'(bus.data_rd), 32'(1));
        nrst = 1'b0;
        @(posedge CPUclk);
        #1;
        check("rr.data_rd_rst", 32'(bus.data_rd), 32'(0));
        check("rr.pc_rst", 32'(bus.inst_addr), 32'(0));
        @(negedge CPUclk);
        nrst            = 1'b1;
        bus.rdata       = 16'hBEEF;
        bus.rdata_valid = 1'b1;
        @(posedge CPUclk);
        #1;
        check("rr.data_rd_after", 32'(bus.data_rd), 32'(0));
        check("rr.inst_req_after", 32'(bus.inst_req), 32'(1));
        check("rr.d_after", 32'(d_q), 32'(0));
        @(negedge CPUclk);
        bus.rdata_valid = 1'b0;
        check("rr.no_retire", 32'(bus.retire), 32'(0));
        do_inst(16'h0009, 0, 0, mk("i22_post_rst", 0, 0, 15'd0, 15'd1, 16'd9, 16'd0, 0));
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge CPUclk);
            n++;
        end
        check("sb_drain2", 32'(sb.size()), 32'(0));
        repeat (2) @(negedge CPUclk);

        // 24-bit instance: widest A-instruction.
        n = 0;
        while (!bus24.inst_req && n < 20) begin
            @(negedge CPUclk);
            n++;
        end
        check("w24.fetch_ready", 32'(bus24.inst_req), 32'(1));
        bus24.inst       = 24'h7FFFFF;
        bus24.inst_valid = 1'b1;
        @(negedge CPUclk);
        bus24.inst_valid = 1'b0;
        check("w24.retire", 32'(bus24.retire), 32'(1));
        @(posedge CPUclk);
        #1;
        check("w24.a", 32'(a24), 32'h7FFFFF);
        check("w24.data_addr", 32'(bus24.data_addr), 32'hFFFFF);
        check("w24.pc", 32'(bus24.inst_addr), 32'(1));
        check("w24.d", 32'(d24), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_core.md
# hack_core

Parametrised, multi-cycle Hack-style CPU core that replaces the fixed 16-bit single-cycle datapath. The core decodes A- and C-instructions fully, so the A and D register loads are real decode outputs rather than tied off. It fetches through a valid handshake and stalls on data-memory reads. It sits between the instruction ROM and data RAM/MMIO on the DE10-Lite top level. A/D/PC are exported for the HEX/LEDR debug display.

## Interface
Parameters:
- DATA_W, 16, datapath and instruction width; must satisfy DATA_W ≥ ADDR_W+1
- ADDR_W, 15, instruction and data address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- CPUclk  in  1  core clock
- nrst  in  1  reset, synchronous, active-low
- inst_req  out  1  fetch request, high in FETCH
- inst_valid  in  1  inst is valid this cycle
- inst  in  DATA_W  instruction word
- inst_addr  out  ADDR_W  current PC
- data_rd  out  1  data read request, high in READ
- rdata_valid  in  1  rdata is valid this cycle
- rdata  in  DATA_W  read data (M)
- data_addr  out  ADDR_W  A[ADDR_W-1:0]
- wdata  out  DATA_W  ALU result
- we  out  1  single-cycle write strobe
- retire  out  1  one-cycle pulse per completed instruction
- a_q, d_q  out  DATA_W  A and D registers, for debug display

## Operation
- FSM states: FETCH, READ, EXEC.
- FETCH: inst_req=1. At the first edge with inst_valid=1, latch inst into IR.
  - Next state is READ if IR is a C-instruction with a=1 (IR[12]).
  - Otherwise next state is EXEC.
- READ: data_rd=1 and data_addr=A. At the first edge with rdata_valid=1, latch rdata into M_q and go to EXEC. Stall indefinitely until then.
- EXEC: always lasts exactly one cycle, asserts retire, then returns to FETCH.
- A-instruction (IR[DATA_W-1]=0):
  - A ← {0, IR[DATA_W-2:0]}.
  - PC ← PC+1.
- C-instruction (IR[DATA_W-1]=1): fields are comp IR[11:6] = zx,nx,zy,ny,f,no; dest IR[5:3] = A,D,M; jump IR[2:0] = lt,eq,gt. IR[DATA_W-2:13] is ignored.
  - ALU inputs: x=D; y=M_q if a=1, else A.
  - dest.A: A ← alu_out. dest.D: D ← alu_out.
  - dest.M: we=1 for the EXEC cycle, with wdata=alu_out and data_addr=old A.
  - Flags: zr = (alu_out==0), ng = alu_out[DATA_W-1].
  - Jump taken if (lt&ng) | (eq&zr) | (gt&!ng&!zr).
  - PC ← old A[ADDR_W-1:0] if the jump is taken, else PC+1.
- Simultaneous events: dest A together with a jump (or dest M) uses the pre-instruction A for the target/address. The new A is visible from the next cycle.
- Arithmetic: all arithmetic is modulo 2^DATA_W. PC increments modulo 2^ADDR_W, so the PC wraps to 0 at the last address.
- Reset (nrst low at an edge, in any state):
  - State ← FETCH, PC ← RESET_PC, A/D/IR/M_q ← 0.
  - Any pending fetch or read is abandoned; a late rdata_valid is ignored.
  - While nrst is low, inst_req/data_rd/we/retire are forced to 0.

## Timing
- Reset values: inst_addr=RESET_PC, data_addr=0, wdata=ALU(D=0, A=0), we=0, retire=0, a_q=d_q=0.
- Minimum latency: 2 cycles per instruction without an M read (FETCH, EXEC); 3 cycles with an M read (FETCH, READ, EXEC).
- Each cycle inst_valid or rdata_valid is low adds one cycle.
- inst_addr is stable from entry to FETCH until the accepting edge. Memory may respond in the same cycle or later.
- we and retire are combinational from state/IR. They are never high outside EXEC.

## Structure
- hack_pkg:
  - state_t enum.
  - Field bit positions: C_BIT, A_BIT, COMP_LSB, DEST_A/D/M, JMP_LT/EQ/GT.
  - Named comp codes: COMP_ZERO=6'b101010, COMP_D=6'b001100, COMP_A=6'b110000, COMP_DP1=6'b011111.
- Sub-module hack_alu #(DATA_W): purely combinational, with x, y, fn[5:0], out, zero. It implements zx/nx/zy/ny/f/no semantics.

## Test plan
- Reset: hold nrst low 3 cycles with inst_valid=1 → inst_addr=0, we=0, retire=0, a_q=d_q=0; inst_req rises the cycle after release.
- 0x0005 then 0xEC10 (D=A), inst_valid tied high → retire every 2nd cycle, d_q=5, inst_addr=2.
- 0x0064, then 0xE7C8 (M=D+1) with D=5 → we=1 for exactly one cycle, data_addr=100, wdata=6.
- 0x0007, then 0xFC10 (D=M) with rdata_valid delayed 3 cycles, rdata=0x1234 → data_rd high 4 cycles, data_addr=7, d_q=0x1234, we=0.
- Jumps (with A=20 loaded by a preceding @20 instruction):
  - D=3 then 0xE301 (D;JGT) → inst_addr=20.
  - D=0 then 0xE301 → PC+1.
  - 0xEA87 (0;JMP) → always 20.
  - Independently: an instruction at inst_addr=0x7FFF with no jump → PC wraps to 0.
- Reset asserted during READ → next cycle data_rd=0, inst_addr=RESET_PC; a late rdata_valid leaves D unchanged.
- Parametric variant: DATA_W=24, ADDR_W=20 → A-instruction 0x7FFFFF loads a_q=0x7FFFFF, data_addr=0xFFFFF.
